// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and types for the two-wide instruction fetch queue.
// Imported by the interface and the queue itself.
package inst_fetch_queue_pkg;

    localparam int INST_WIDTH      = 32;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int IF_BATCH_SIZE   = 2;
    localparam int IFQ_DEPTH       = 8;

    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and PreDecode-side signals of the fetch queue.
// master = the surrounding pipeline, slave = the queue.
interface inst_fetch_queue_if #(
    parameter int DEPTH = inst_fetch_queue_pkg::IFQ_DEPTH
) ();
    import inst_fetch_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic                       flush;
    logic [IF_BATCH_SIZE-1:0]   in_inst_valid;
    logic [INST_ADDR_WIDTH-1:0] in_pc_0;
    logic [INST_ADDR_WIDTH-1:0] in_pc_1;
    logic [INST_WIDTH-1:0]      in_inst_0;
    logic [INST_WIDTH-1:0]      in_inst_1;
    logic                       in_ready;
    logic                       out_stall;
    logic [IF_BATCH_SIZE-1:0]   out_inst_valid;
    logic [INST_ADDR_WIDTH-1:0] out_pc_0;
    logic [INST_ADDR_WIDTH-1:0] out_pc_1;
    logic [INST_WIDTH-1:0]      out_inst_0;
    logic [INST_WIDTH-1:0]      out_inst_1;
    logic [PTR_W:0]             out_count;

    modport master (
        output flush, in_inst_valid, in_pc_0, in_pc_1, in_inst_0, in_inst_1, out_stall,
        input  in_ready, out_inst_valid, out_pc_0, out_pc_1, out_inst_0, out_inst_1, out_count
    );

    modport slave (
        input  flush, in_inst_valid, in_pc_0, in_pc_1, in_inst_0, in_inst_1, out_stall,
        output in_ready, out_inst_valid, out_pc_0, out_pc_1, out_inst_0, out_inst_1, out_count
    );

endinterface

// File: rtl/inst_fetch_queue.sv
// Two-wide in-order fetch queue between IF and PreDecode; buffers {pc, inst}
// pairs, presents the oldest one or two, and empties on flush.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_fetch_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t READY_MAX = cnt_t'(DEPTH - 2);

    ptr_t         head, tail, head_p1, tail_p1;
    cnt_t         count, enq_n, deq_n;
    logic         in_ready, enq_en, deq_en;
    logic [1:0]   out_valid;
    fetch_entry_t wr_first, wr_second, rd_0, rd_1;
    fetch_entry_t entries [DEPTH];

    assign head_p1 = head + ptr_t'(1);
    assign tail_p1 = tail + ptr_t'(1);

    // A lone valid slot (either position) is compacted into the tail entry.
    always_comb begin
        in_ready  = (count <= READY_MAX);
        enq_en    = in_ready && !bus.flush;
        wr_first  = bus.in_inst_valid[0] ? {bus.in_pc_0, bus.in_inst_0}
                                         : {bus.in_pc_1, bus.in_inst_1};
        wr_second = {bus.in_pc_1, bus.in_inst_1};
        enq_n     = enq_en ? cnt_t'(popcount2(bus.in_inst_valid)) : '0;

        if (count == '0)
            out_valid = 2'b00;
        else if (count == cnt_t'(1))
            out_valid = 2'b01;
        else
            out_valid = 2'b11;

        deq_en = !bus.out_stall && !bus.flush;
        deq_n  = deq_en ? cnt_t'(popcount2(out_valid)) : '0;
        rd_0   = out_valid[0] ? entries[head]    : '0;
        rd_1   = out_valid[1] ? entries[head_p1] : '0;
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_inst_valid = out_valid;
    assign bus.out_pc_0       = rd_0.pc;
    assign bus.out_inst_0     = rd_0.inst;
    assign bus.out_pc_1       = rd_1.pc;
    assign bus.out_inst_1     = rd_1.inst;
    assign bus.out_count      = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(deq_n);
            tail  <= tail + ptr_t'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    // Storage carries no reset; stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (enq_en) begin
            if (enq_n != '0)
                entries[tail] <= wr_first;
            if (enq_n == cnt_t'(2))
                entries[tail_p1] <= wr_second;
        end
    end

endmodule
